// File: rtl/rx_huge_page_manager.sv
// RX huge-page manager: tracks two host pages, hands out the next write
// address to the TLP sender and closes pages with a notification write.
module rx_huge_page_manager #(
  parameter int unsigned PAGE_QW_LOG2 = 18,
  parameter int unsigned HDR_QW       = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        hp_wr_en,
  input  logic        hp_wr_idx,
  input  logic [63:0] hp_wr_addr,
  output logic [1:0]  hp_ready,
  output logic        active_idx,
  output logic        cur_valid,
  output logic [63:0] cur_addr,
  input  logic        tlp_issue,
  input  logic [4:0]  tlp_qwords,
  input  logic        page_done_req,
  output logic        page_done_ack,
  output logic        notify_req,
  output logic [63:0] notify_addr,
  output logic [31:0] notify_data,
  input  logic        notify_ack,
  output logic [1:0]  err_sticky,
  input  logic        err_clr
);

  localparam int unsigned OW = PAGE_QW_LOG2 + 1;
  localparam logic [OW-1:0] HDR = OW'(HDR_QW);
  localparam logic [OW:0] PAGE_QW = {1'b0, 1'b1, {PAGE_QW_LOG2{1'b0}}};

  typedef enum logic [1:0] {WAIT_PAGE, ACTIVE, NOTIFY, CLOSE} state_t;

  state_t        state;
  logic [63:0]   base [2];
  logic [OW-1:0] offset;
  logic [OW:0]   off_sum;
  logic [OW-1:0] off_next;
  logic          issue_bad;
  logic          wr_conflict;
  logic          unused_addr_bits;

  // Page bases are 2 MB aligned; the low address bits carry no information.
  assign unused_addr_bits = ^hp_wr_addr[20:0];

  always_comb begin
    off_sum     = {1'b0, offset} + (OW+1)'(tlp_qwords);
    issue_bad   = tlp_issue && ((tlp_qwords == 5'd0) || (tlp_qwords > 5'd16) ||
                                (state != ACTIVE) || (off_sum > PAGE_QW));
    off_next    = (tlp_issue && !issue_bad) ? off_sum[OW-1:0] : offset;
    wr_conflict = hp_wr_en && hp_ready[hp_wr_idx];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= WAIT_PAGE;
      base[0]       <= '0;
      base[1]       <= '0;
      hp_ready      <= '0;
      active_idx    <= 1'b0;
      offset        <= HDR;
      cur_valid     <= 1'b0;
      cur_addr      <= '0;
      notify_req    <= 1'b0;
      notify_addr   <= '0;
      notify_data   <= '0;
      page_done_ack <= 1'b0;
      err_sticky    <= '0;
    end else begin
      page_done_ack <= 1'b0;
      cur_addr      <= base[active_idx] + {{(61-OW){1'b0}}, offset, 3'b000};
      err_sticky    <= err_clr ? '0 : (err_sticky | {issue_bad, wr_conflict});

      if (hp_wr_en && !hp_ready[hp_wr_idx]) begin
        base[hp_wr_idx]     <= {hp_wr_addr[63:21], 21'b0};
        hp_ready[hp_wr_idx] <= 1'b1;
      end

      case (state)
        WAIT_PAGE: begin
          cur_valid <= 1'b0;
          if (hp_ready[active_idx]) begin
            offset <= HDR;
            state  <= ACTIVE;
          end
        end
        ACTIVE: begin
          // A same-cycle issue is folded into the count before the page closes.
          offset    <= off_next;
          cur_valid <= !page_done_req;
          if (page_done_req) begin
            state       <= NOTIFY;
            notify_req  <= 1'b1;
            notify_addr <= base[active_idx];
            notify_data <= 32'(off_next - HDR);
          end
        end
        NOTIFY: begin
          cur_valid <= 1'b0;
          if (notify_ack) begin
            notify_req <= 1'b0;
            state      <= CLOSE;
          end
        end
        CLOSE: begin
          // Host writes can only target the non-active slot here, so no clash on hp_ready.
          hp_ready[active_idx] <= 1'b0;
          active_idx           <= !active_idx;
          page_done_ack        <= 1'b1;
          state                <= WAIT_PAGE;
        end
        default: state <= WAIT_PAGE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_huge_page_manager.sv
// Scenario bench for rx_huge_page_manager; notification writes are checked
// against a scoreboard queue filled when each page close is requested.
module tb_rx_huge_page_manager;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        hp_wr_en;
  logic        hp_wr_idx;
  logic [63:0] hp_wr_addr;
  logic [1:0]  hp_ready;
  logic        active_idx;
  logic        cur_valid;
  logic [63:0] cur_addr;
  logic        tlp_issue;
  logic [4:0]  tlp_qwords;
  logic        page_done_req;
  logic        page_done_ack;
  logic        notify_req;
  logic [63:0] notify_addr;
  logic [31:0] notify_data;
  logic        notify_ack;
  logic [1:0]  err_sticky;
  logic        err_clr;

  typedef struct {
    logic [63:0] addr;
    logic [31:0] data;
  } note_t;

  note_t       nq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [63:0] exp_base [2];
  int          exp_off;
  logic        exp_idx;
  logic        exp_act;

  rx_huge_page_manager #(.PAGE_QW_LOG2(18), .HDR_QW(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .hp_wr_en(hp_wr_en), .hp_wr_idx(hp_wr_idx), .hp_wr_addr(hp_wr_addr),
    .hp_ready(hp_ready), .active_idx(active_idx),
    .cur_valid(cur_valid), .cur_addr(cur_addr),
    .tlp_issue(tlp_issue), .tlp_qwords(tlp_qwords),
    .page_done_req(page_done_req), .page_done_ack(page_done_ack),
    .notify_req(notify_req), .notify_addr(notify_addr), .notify_data(notify_data),
    .notify_ack(notify_ack), .err_sticky(err_sticky), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time expired, got no finish want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] exp_addr();
    return exp_base[exp_idx] + 64'(exp_off) * 64'd8;
  endfunction

  task automatic host_write(input logic idx, input logic [63:0] addr);
    hp_wr_en = 1'b1; hp_wr_idx = idx; hp_wr_addr = addr;
    tick();
    hp_wr_en = 1'b0;
  endtask

  task automatic issue(input int qw);
    tlp_issue = 1'b1; tlp_qwords = 5'(qw);
    tick();
    tlp_issue = 1'b0;
    if (exp_act && qw >= 1 && qw <= 16 && exp_off + qw <= 262144) exp_off += qw;
  endtask

  task automatic clear_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  // Requests a close (optionally with a same-cycle issue), checks the notify
  // against the scoreboard, acks after ack_delay cycles and checks the ack pulse.
  task automatic run_close(input int qw, input int ack_delay);
    note_t e;
    if (qw != 0 && exp_act && qw <= 16 && exp_off + qw <= 262144) exp_off += qw;
    nq.push_back('{addr: exp_base[exp_idx], data: 32'(exp_off - 16)});
    page_done_req = 1'b1;
    tlp_issue = (qw != 0); tlp_qwords = 5'(qw);
    tick();
    page_done_req = 1'b0; tlp_issue = 1'b0; exp_act = 1'b0;
    for (int i = 0; i < 8 && !notify_req; i++) tick();
    n_checks++;
    if (notify_req !== 1'b1) begin
      n_fail++; $display("FAIL notify_req_rise: got %b want 1", notify_req);
    end
    if (nq.size() == 0) begin
      n_checks++; n_fail++; $display("FAIL scoreboard_empty: got 0 entries want 1");
    end else begin
      e = nq.pop_front();
      n_checks++;
      if (notify_addr !== e.addr) begin
        n_fail++; $display("FAIL notify_addr: got %h want %h", notify_addr, e.addr);
      end
      n_checks++;
      if (notify_data !== e.data) begin
        n_fail++; $display("FAIL notify_data: got %h want %h", notify_data, e.data);
      end
      for (int i = 0; i < ack_delay; i++) begin
        tick();
        n_checks++;
        if (notify_req !== 1'b1 || notify_data !== e.data || notify_addr !== e.addr) begin
          n_fail++;
          $display("FAIL notify_hold: got req=%b data=%h addr=%h want req=1 data=%h addr=%h",
                   notify_req, notify_data, notify_addr, e.data, e.addr);
        end
      end
    end
    notify_ack = 1'b1;
    tick();
    notify_ack = 1'b0;
    n_checks++;
    if (notify_req !== 1'b0) begin
      n_fail++; $display("FAIL notify_req_drop: got %b want 0", notify_req);
    end
    tick();
    n_checks++;
    if (page_done_ack !== 1'b1) begin
      n_fail++; $display("FAIL page_done_ack_pulse: got %b want 1", page_done_ack);
    end
    n_checks++;
    if (active_idx !== !exp_idx) begin
      n_fail++; $display("FAIL active_toggle: got %b want %b", active_idx, !exp_idx);
    end
    exp_idx = !exp_idx;
    tick();
    n_checks++;
    if (page_done_ack !== 1'b0) begin
      n_fail++; $display("FAIL page_done_ack_single: got %b want 0", page_done_ack);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0; hp_wr_en = 1'b0; hp_wr_idx = 1'b0; hp_wr_addr = '0;
    tlp_issue = 1'b0; tlp_qwords = '0; page_done_req = 1'b0;
    notify_ack = 1'b0; err_clr = 1'b0;
    exp_base[0] = '0; exp_base[1] = '0; exp_off = 16; exp_idx = 1'b0; exp_act = 1'b0;
    tick(); tick();
    n_checks++;
    if ({hp_ready, cur_valid, notify_req, page_done_ack, err_sticky, active_idx} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b valid=%b nreq=%b ack=%b err=%b idx=%b want all 0",
               hp_ready, cur_valid, notify_req, page_done_ack, err_sticky, active_idx);
    end
    n_checks++;
    if (cur_addr !== 64'h0 || notify_addr !== 64'h0 || notify_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got cur=%h naddr=%h ndata=%h want 0", cur_addr, notify_addr, notify_data);
    end
    reset_n = 1'b1;
    tick(); tick();
    n_checks++;
    if (cur_valid !== 1'b0 || hp_ready !== 2'b00) begin
      n_fail++; $display("FAIL idle_after_reset: got valid=%b ready=%b want 0 00", cur_valid, hp_ready);
    end
  endtask

  task automatic test_first_page();
    host_write(1'b0, 64'h1_0020_0000);
    exp_base[0] = 64'h1_0020_0000;
    n_checks++;
    if (hp_ready !== 2'b01) begin
      n_fail++; $display("FAIL hp_ready_set: got %b want 01", hp_ready);
    end
    for (int i = 0; i < 8 && !cur_valid; i++) tick();
    exp_act = 1'b1; exp_off = 16;
    n_checks++;
    if (cur_valid !== 1'b1 || cur_addr !== exp_addr()) begin
      n_fail++; $display("FAIL first_valid: got valid=%b addr=%h want 1 %h", cur_valid, cur_addr, exp_addr());
    end
    issue(16); tick();
    n_checks++;
    if (cur_addr !== exp_addr()) begin
      n_fail++; $display("FAIL issue16_addr: got %h want %h", cur_addr, exp_addr());
    end
    issue(5); tick();
    n_checks++;
    if (cur_addr !== exp_addr()) begin
      n_fail++; $display("FAIL issue5_addr: got %h want %h", cur_addr, exp_addr());
    end
  endtask

  task automatic test_close_same_cycle();
    run_close(3, 3);
    n_checks++;
    if (hp_ready !== 2'b00 || cur_valid !== 1'b0) begin
      n_fail++; $display("FAIL after_close: got ready=%b valid=%b want 00 0", hp_ready, cur_valid);
    end
  endtask

  task automatic test_second_page();
    host_write(1'b1, 64'h2_0001_F00F);
    exp_base[1] = 64'h2_0000_0000;
    for (int i = 0; i < 8 && !cur_valid; i++) tick();
    exp_act = 1'b1; exp_off = 16;
    n_checks++;
    if (cur_valid !== 1'b1 || cur_addr !== exp_addr()) begin
      n_fail++; $display("FAIL second_valid: got valid=%b addr=%h want 1 %h", cur_valid, cur_addr, exp_addr());
    end
    host_write(1'b1, 64'h5555_0000_0000);
    tick();
    n_checks++;
    if (err_sticky !== 2'b01 || cur_addr !== exp_addr()) begin
      n_fail++; $display("FAIL write_conflict: got err=%b addr=%h want 01 %h", err_sticky, cur_addr, exp_addr());
    end
    clear_err();
    n_checks++;
    if (err_sticky !== 2'b00) begin
      n_fail++; $display("FAIL err_clr: got %b want 00", err_sticky);
    end
    issue(0); tick();
    n_checks++;
    if (err_sticky !== 2'b10 || cur_addr !== exp_addr()) begin
      n_fail++; $display("FAIL zero_qwords: got err=%b addr=%h want 10 %h", err_sticky, cur_addr, exp_addr());
    end
    clear_err();
    issue(17); tick();
    n_checks++;
    if (err_sticky !== 2'b10 || cur_addr !== exp_addr()) begin
      n_fail++; $display("FAIL over16_qwords: got err=%b addr=%h want 10 %h", err_sticky, cur_addr, exp_addr());
    end
    err_clr = 1'b1; tlp_issue = 1'b1; tlp_qwords = 5'd0;
    tick();
    err_clr = 1'b0; tlp_issue = 1'b0;
    n_checks++;
    if (err_sticky !== 2'b00) begin
      n_fail++; $display("FAIL err_clr_priority: got %b want 00", err_sticky);
    end
  endtask

  task automatic test_back_to_back();
    host_write(1'b0, 64'h3_0000_0000);
    exp_base[0] = 64'h3_0000_0000;
    n_checks++;
    if (hp_ready !== 2'b11) begin
      n_fail++; $display("FAIL both_ready: got %b want 11", hp_ready);
    end
    run_close(0, 0);
    for (int i = 0; i < 4 && !cur_valid; i++) tick();
    exp_act = 1'b1; exp_off = 16;
    n_checks++;
    if (cur_valid !== 1'b1 || cur_addr !== exp_addr() || hp_ready !== 2'b01) begin
      n_fail++;
      $display("FAIL back_to_back: got valid=%b addr=%h ready=%b want 1 %h 01",
               cur_valid, cur_addr, hp_ready, exp_addr());
    end
  endtask

  task automatic test_fill();
    tlp_issue = 1'b1; tlp_qwords = 5'd16;
    repeat (16382) tick();
    tlp_qwords = 5'd8;
    tick();
    tlp_issue = 1'b0;
    exp_off += 16 * 16382 + 8;
    tick();
    n_checks++;
    if (cur_addr !== exp_addr() || err_sticky !== 2'b00) begin
      n_fail++; $display("FAIL fill_addr: got addr=%h err=%b want %h 00", cur_addr, err_sticky, exp_addr());
    end
    issue(16); tick();
    n_checks++;
    if (err_sticky !== 2'b10 || cur_addr !== exp_addr()) begin
      n_fail++; $display("FAIL overflow_issue: got err=%b addr=%h want 10 %h", err_sticky, cur_addr, exp_addr());
    end
    clear_err();
    issue(8); tick();
    n_checks++;
    if (cur_addr !== 64'h3_0020_0000 || err_sticky !== 2'b00) begin
      n_fail++; $display("FAIL exact_full: got addr=%h err=%b want 300200000 00", cur_addr, err_sticky);
    end
    issue(1); tick();
    n_checks++;
    if (err_sticky !== 2'b10 || cur_addr !== exp_addr()) begin
      n_fail++; $display("FAIL full_plus_one: got err=%b addr=%h want 10 %h", err_sticky, cur_addr, exp_addr());
    end
    clear_err();
    run_close(0, 1);
    issue(4); tick();
    n_checks++;
    if (err_sticky !== 2'b10 || cur_valid !== 1'b0) begin
      n_fail++; $display("FAIL issue_not_active: got err=%b valid=%b want 10 0", err_sticky, cur_valid);
    end
    clear_err();
  endtask

  task automatic test_reset_mid_notify();
    int acks = 0;
    host_write(1'b1, 64'h4_0000_0000);
    for (int i = 0; i < 8 && !cur_valid; i++) tick();
    page_done_req = 1'b1;
    tick();
    page_done_req = 1'b0;
    for (int i = 0; i < 8 && !notify_req; i++) tick();
    n_checks++;
    if (notify_req !== 1'b1) begin
      n_fail++; $display("FAIL notify_before_reset: got %b want 1", notify_req);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (notify_req !== 1'b0 || hp_ready !== 2'b00 || cur_valid !== 1'b0 || active_idx !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got nreq=%b ready=%b valid=%b idx=%b want 0 00 0 0",
               notify_req, hp_ready, cur_valid, active_idx);
    end
    tick(); tick();
    notify_ack = 1'b1;
    reset_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (page_done_ack) acks++;
    end
    notify_ack = 1'b0;
    n_checks++;
    if (acks != 0 || notify_req !== 1'b0 || hp_ready !== 2'b00) begin
      n_fail++; $display("FAIL no_ack_after_reset: got acks=%0d nreq=%b ready=%b want 0 0 00", acks, notify_req, hp_ready);
    end
  endtask

  initial begin
    test_reset();
    test_first_page();
    test_close_same_cycle();
    test_second_page();
    test_back_to_back();
    test_fill();
    test_reset_mid_notify();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
